// File: rtl/aca_ii_varlat_adder_pkg.sv
// Shared types and elaboration helpers for the ACA-II variable-latency adder.
package aca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIX,
    HOLD
  } state_t;

  // Number of overlapping Q-bit windows spaced Q/2 apart across N bits.
  function automatic int unsigned aca_windows(input int unsigned n, input int unsigned q);
    if (q < 2) return 1;
    return (2 * n) / q - 1;
  endfunction

  // True when the parameter set describes a buildable adder.
  function automatic bit aca_params_ok(input int unsigned n, input int unsigned q,
                                       input int unsigned cnt_w);
    if (q < 2) return 1'b0;
    if ((q % 2) != 0) return 1'b0;
    if (n < q) return 1'b0;
    if ((n % (q / 2)) != 0) return 1'b0;
    if (cnt_w < 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/aca_ii_varlat_adder_core.sv
// Combinational ACA-II datapath: windowed approximate sum plus error detect.
module aca_ii_core
  import aca_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned Q = 4
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N:0]   approx,
  output logic         err
);

  localparam int unsigned H = Q / 2;
  localparam int unsigned K = aca_windows(N, Q);

  logic [Q:0] w [K];
  logic [N:0] exact;

  // Each window is an independent Q-bit add with no carry-in.
  always_comb begin
    for (int unsigned k = 0; k < K; k++) begin
      w[k] = {1'b0, in1[k*H +: Q]} + {1'b0, in2[k*H +: Q]};
    end
  end

  // Window 0 supplies the low Q bits; every later window contributes only its
  // upper half, and the last window's carry-out becomes the sum's MSB.
  always_comb begin
    approx = '0;
    approx[Q-1:0] = w[0][Q-1:0];
    for (int unsigned k = 1; k < K; k++) begin
      approx[k*H+H +: H] = w[k][Q-1:H];
    end
    approx[N] = w[K-1][Q];
  end

  assign exact = {1'b0, in1} + {1'b0, in2};
  assign err   = (approx != exact);

endmodule

// File: rtl/aca_ii_varlat_adder.sv
// ACA-II adder with registered error flag, optional one-cycle correction,
// valid/ready handshakes and a saturating error counter.
module aca_ii_varlat_adder
  import aca_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned Q     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in1,
  input  logic [N-1:0]     in2,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       res,
  output logic             err_flag,
  output logic             corrected,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] err_cnt
);

  if (!aca_params_ok(N, Q, CNT_W)) begin : g_bad_params
    $error("aca_ii_varlat_adder: illegal N/Q/CNT_W combination");
  end

  state_t         state;
  state_t         nxt;
  logic [N:0]     approx;
  logic           err;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           accept;
  logic           load_approx;
  logic           load_exact;
  logic           latch_ops;

  aca_ii_core #(
    .N(N),
    .Q(Q)
  ) u_core (
    .in1   (in1),
    .in2   (in2),
    .approx(approx),
    .err   (err)
  );

  // Next-state, handshake outputs and datapath load strobes.
  always_comb begin
    nxt         = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    load_approx = 1'b0;
    load_exact  = 1'b0;
    latch_ops   = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      FIX: begin
        load_exact = 1'b1;
        nxt        = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) begin
      if (mode && err) begin
        latch_ops = 1'b1;
        nxt       = FIX;
      end else begin
        load_approx = 1'b1;
        nxt         = HOLD;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Operand latch for correction and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      res       <= '0;
      err_flag  <= 1'b0;
      corrected <= 1'b0;
    end else begin
      if (latch_ops) begin
        a_q <= in1;
        b_q <= in2;
      end
      if (load_approx) begin
        res       <= approx;
        err_flag  <= err;
        corrected <= 1'b0;
      end else if (load_exact) begin
        res       <= {1'b0, a_q} + {1'b0, b_q};
        err_flag  <= 1'b1;
        corrected <= 1'b1;
      end
    end
  end

  // Saturating count of accepted operations whose approximation was wrong.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      err_cnt <= '0;
    end else if (accept && err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aca_ii_varlat_adder.sv
// Self-checking bench for aca_ii_varlat_adder (N=16,Q=4 main instance, a
// CNT_W=2 twin for saturation, and a Q==N exact twin).
module tb_aca_ii_varlat_adder;

  localparam int unsigned N = 16;
  localparam int unsigned Q = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in1 = '0;
  logic [N-1:0]  in2 = '0;
  logic          mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N:0]    res;
  logic          err_flag;
  logic          corrected;
  logic          stat_clr = 1'b0;
  logic [15:0]   err_cnt;

  logic          in_ready2, out_valid2, err_flag2, corrected2;
  logic [N:0]    res2;
  logic [1:0]    err_cnt2;

  logic          in_ready3, out_valid3, err_flag3, corrected3;
  logic [N:0]    res3;
  logic [15:0]   err_cnt3;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  int unsigned   cnt_m = 0;
  int unsigned   cnt2_m = 0;

  always #5 clk = ~clk;

  aca_ii_varlat_adder #(.N(N), .Q(Q), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .err_flag(err_flag),
    .corrected(corrected), .stat_clr(stat_clr), .err_cnt(err_cnt)
  );

  aca_ii_varlat_adder #(.N(N), .Q(Q), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in1(in1), .in2(in2), .mode(mode), .out_valid(out_valid2),
    .out_ready(out_ready), .res(res2), .err_flag(err_flag2),
    .corrected(corrected2), .stat_clr(stat_clr), .err_cnt(err_cnt2)
  );

  aca_ii_varlat_adder #(.N(N), .Q(N), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in1(in1), .in2(in2), .mode(mode), .out_valid(out_valid3),
    .out_ready(1'b1), .res(res3), .err_flag(err_flag3),
    .corrected(corrected3), .stat_clr(stat_clr), .err_cnt(err_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Approximate sum: each output slice sees only the carries generated
  // within the Q-bit window that ends at it.
  function automatic int unsigned approx_model(input int unsigned a, input int unsigned b);
    int unsigned h, nw, mq, mh, win, r;
    h  = Q / 2;
    nw = 2 * N / Q - 1;
    mq = (1 << Q) - 1;
    mh = (1 << h) - 1;
    r  = 0;
    for (int unsigned i = 0; i < nw; i++) begin
      win = ((a >> (i * h)) & mq) + ((b >> (i * h)) & mq);
      if (i == 0) r = r | (win & mq);
      else        r = r | (((win >> h) & mh) << (i * h + h));
      if (i == nw - 1) r = r | ((win >> Q) << N);
    end
    return r;
  endfunction

  // Error when an exact carry enters a window whose lower half fully propagates.
  function automatic bit err_model(input int unsigned a, input int unsigned b);
    int unsigned h, nw, p, mh, cin;
    bit e;
    h  = Q / 2;
    nw = 2 * N / Q - 1;
    mh = (1 << h) - 1;
    e  = 1'b0;
    for (int unsigned i = 1; i < nw; i++) begin
      p   = i * h;
      cin = (((a & ((1 << p) - 1)) + (b & ((1 << p) - 1))) >> p) & 1;
      if (cin == 1 && (((a ^ b) >> p) & mh) == mh) e = 1'b1;
    end
    return e;
  endfunction

  task automatic count_err(input bit e, input bit clr);
    if (clr) begin
      cnt_m  = 0;
      cnt2_m = 0;
    end else if (e) begin
      if (cnt_m < 65535) cnt_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
  endtask

  // One operation through the handshake; called #1 after a clock edge.
  task automatic do_op(input int unsigned a, input int unsigned b, input bit m, input bit clr);
    int unsigned ea, ex, lat, elat;
    bit e, fix;
    ea  = approx_model(a, b);
    e   = err_model(a, b);
    ex  = a + b;
    fix = m && e;
    in1 = N'(a);
    in2 = N'(b);
    mode = m;
    in_valid = 1'b1;
    stat_clr = clr;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    stat_clr = 1'b0;
    count_err(e, clr);
    chk("exact_twin_valid", 32'(out_valid3), 32'd1);
    chk("exact_twin_res", 32'(res3), ex);
    chk("exact_twin_err", 32'(err_flag3), 32'd0);
    lat = 1;
    while (!out_valid && lat < 4) begin
      chk("in_ready_during_fix", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    elat = fix ? 2 : 1;
    chk("latency", lat, elat);
    chk("res", 32'(res), fix ? ex : ea);
    chk("err_flag", 32'(err_flag), 32'(e));
    chk("corrected", 32'(corrected), 32'(fix));
    chk("err_cnt", 32'(err_cnt), cnt_m);
    chk("err_cnt_w2", 32'(err_cnt2), cnt2_m);
  endtask

  initial begin
    int unsigned r1, r2, r3;
    bit rm;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_corrected", 32'(corrected), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Approximate result with an error, then the corrected variant
    do_op(32'h000F, 32'h0001, 1'b0, 1'b0);
    chk("t1_res_const", 32'(res), 32'h00000);
    @(posedge clk); #1;
    do_op(32'h000F, 32'h0001, 1'b1, 1'b0);
    chk("t2_res_const", 32'(res), 32'h00010);
    @(posedge clk); #1;

    // Error-free boundary cases including carry into res[N]
    do_op(32'h8000, 32'h8000, 1'b1, 1'b0);
    chk("t3_carry_out", 32'(res), 32'h10000);
    do_op(32'hFFFF, 32'h0000, 1'b1, 1'b0);
    chk("t3_all_ones", 32'(res), 32'h0FFFF);
    @(posedge clk); #1;

    // Back-to-back throughput, then backpressure
    mode = 1'b0;
    in_valid = 1'b1;
    in1 = 16'h1234; in2 = 16'h0001;
    @(posedge clk); #1;
    chk("b2b_valid0", 32'(out_valid), 32'd1);
    chk("b2b_res0", 32'(res), 32'h01235);
    in1 = 16'h0101; in2 = 16'h0202;
    @(posedge clk); #1;
    chk("b2b_valid1", 32'(out_valid), 32'd1);
    chk("b2b_res1", 32'(res), 32'h00303);
    in1 = 16'h8000; in2 = 16'h8000;
    @(posedge clk); #1;
    chk("b2b_valid2", 32'(out_valid), 32'd1);
    chk("b2b_res2", 32'(res), 32'h10000);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_res", 32'(res), 32'h10000);
      chk("stall_in_ready_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_to_idle", 32'(out_valid), 32'd0);

    // Counter saturation on the CNT_W=2 twin, then clear beats increment
    for (int i = 0; i < 5; i++) do_op(32'h000F, 32'h0001, 1'b0, 1'b0);
    chk("sat_cnt_w2", 32'(err_cnt2), 32'd3);
    do_op(32'h000F, 32'h0001, 1'b0, 1'b1);
    chk("clr_priority_w2", 32'(err_cnt2), 32'd0);
    chk("clr_priority", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a correction
    in1 = 16'h000F; in2 = 16'h0001; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    count_err(1'b1, 1'b0);
    chk("fix_in_ready", 32'(in_ready), 32'd0);
    chk("fix_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_err(1'b0, 1'b1);
    chk("midfix_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midfix_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midfix_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midfix_rst_res", 32'(res), 32'd0);
    do_op(32'h00FF, 32'h0001, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      r1 = $urandom & 32'hFFFF;
      r3 = $urandom_range(0, 2);
      if (r3 == 0) r2 = (~r1 + $urandom_range(0, 3)) & 32'hFFFF;
      else         r2 = $urandom & 32'hFFFF;
      rm = 1'($urandom_range(0, 1));
      do_op(r1, r2, rm, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aca_ii_varlat_adder.md
Name: aca_ii_varlat_adder

Overview:
- Parametrised ACA-II almost-correct adder: N-bit operands, Q-bit overlapping sub-adder windows spaced Q/2 apart.
- Adds registered error detection, an optional one-cycle correction (variable latency), valid/ready handshakes and a saturating error counter.
- Sits in the approximate FP add/sub datapath as the mantissa adder, so exact/approximate mode can be chosen per operation.

Parameters:
N, 16, operand width; N >= Q, N mod (Q/2) == 0
Q, 4, sub-adder window width; even, >= 2; Q == N degenerates to an exact adder
CNT_W, 16, width of err_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand valid
in_ready  out  1  block can accept operands
in1  in  N  operand A, unsigned
in2  in  N  operand B, unsigned
mode  in  1  0 = approximate result, 1 = correct on detected error
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
res  out  N+1  sum
err_flag  out  1  ACA-II approximation of this operation differed from the exact sum
corrected  out  1  res is the corrected exact sum
stat_clr  in  1  clear err_cnt
err_cnt  out  CNT_W  saturating count of operations with err_flag=1

Behaviour:
- Window count and placement:
  - K = 2N/Q - 1.
  - Window k covers bits [k*Q/2 +: Q] and is a Q-bit add with carry-in 0, giving a (Q+1)-bit result w_k.
- Approximate result assembly:
  - res[Q-1:0] = w_0[Q-1:0].
  - For 1 <= k < K-1: res[k*Q/2+Q/2 +: Q/2] = w_k[Q-1:Q/2].
  - For k = K-1: res[N:N-Q/2] = w_{K-1}[Q:Q/2].
- Error detect:
  - err = (approx != in1+in2).
  - Equivalent form: OR over k>=1 of (exact carry into bit k*Q/2) AND (all bits in window k's lower half propagate).
- Handshake:
  - Accept when in_valid && in_ready at a rising edge; mode is sampled with the operands.
  - Result transfers when out_valid && out_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - FIX: correction cycle; in_ready=0, out_valid=0.
  - HOLD: out_valid=1; in_ready=out_ready.
- Transitions:
  - IDLE/HOLD on accept:
    - If mode=0 or err=0: load res=approx, err_flag=err, corrected=0; go to HOLD.
    - If mode=1 and err=1: latch operands; go to FIX.
  - HOLD with out_ready and no accept -> IDLE.
  - HOLD with out_ready=0: hold res, err_flag and corrected stable; in_ready=0.
  - FIX -> HOLD: load res=in1+in2 (exact), err_flag=1, corrected=1.
- Latency and throughput:
  - Latency 1 cycle (accept edge to out_valid) when not corrected; 2 cycles when corrected.
  - Throughput 1 op/cycle when out_ready stays high and no corrections occur.
- err_cnt:
  - Increments by 1 at each accept with err=1, regardless of mode.
  - Saturates at 2^CNT_W-1.
  - stat_clr has priority over a same-cycle increment (result 0).
- Reset:
  - rst at any edge, including during FIX or HOLD: state=IDLE, out_valid=0, res=0, err_flag=0, corrected=0, err_cnt=0.
  - Any in-flight operation is dropped; in_ready=1 on the cycle after reset.
- Boundaries:
  - Q == N: err is always 0.
  - Carry out of the top window lands in res[N].
  - Every parameter constraint violation is an elaboration-time error.

Decomposition:
- Package aca_pkg:
  - function aca_windows(N,Q) returning K.
  - FSM state typedef (IDLE, FIX, HOLD).
  - Parameter-legality check function.
- Sub-module aca_ii_core (N, Q): combinational, in1/in2 -> approx[N:0], err.
- The top-level module holds the FSM, registers and counter.

Test Plan:
1. N=16,Q=4, in1=0x000F, in2=0x0001, mode=0 -> one cycle after accept: res=0x00000, err_flag=1, corrected=0, err_cnt=1.
2. Same operands, mode=1 -> out_valid two cycles after accept: res=0x00010, err_flag=1, corrected=1; in_ready=0 during FIX.
3. in1=0x8000, in2=0x8000, mode=1 -> latency 1: res=0x10000, err_flag=0. Then in1=0xFFFF, in2=0x0000 -> res=0x0FFFF, err_flag=0.
4. Three error-free ops on consecutive cycles with out_ready=1 -> out_valid high three consecutive cycles, results in order. Then drop out_ready for 2 cycles -> in_ready=0 and res stable.
5. CNT_W=2: five erroneous ops -> err_cnt=3 (saturated). stat_clr concurrent with a sixth erroneous accept -> err_cnt=0.
6. rst asserted during FIX -> next cycle out_valid=0, in_ready=1, err_cnt=0; a new op then completes normally.
